// File: rtl/sd_blk_arbiter.sv
// rtl/sd_blk_arbiter.sv - round-robin arbiter sharing one SD block host channel between four drives
//
// Optional feature: define SD_ARB_TIMEOUT_EN to build in a per-grant watchdog
// that aborts a grant after TIMEOUT_CYCLES cycles and sets sticky timeout_err.
//
// Ports:
//   CLK           system clock, state updates on the falling edge
//   RESET_N       asynchronous active-low reset
//   drv_lba       per-drive requested LBA
//   drv_rd/drv_wr per-drive read/write request levels
//   drv_ack       per-drive ack (owner only)
//   drv_buff_din  per-drive buffer read data
//   drv_buff_wr   per-drive buffer write strobe (owner only)
//   sd_lba        host LBA, latched at grant
//   sd_rd/sd_wr   host read/write request (registered)
//   sd_ack        host ack
//   sd_buff_wr    host buffer write strobe
//   sd_buff_din   owner's buffer data, 0 outside a transfer
//   owner         current or last owner index
//   busy          arbiter not idle
//   timeout_err   sticky watchdog abort flag
module sd_blk_arbiter #(
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd10_000_000
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic [31:0] drv_lba [4],
    input  logic [3:0]  drv_rd,
    input  logic [3:0]  drv_wr,
    output logic [3:0]  drv_ack,
    input  logic [7:0]  drv_buff_din [4],
    output logic [3:0]  drv_buff_wr,
    output logic [31:0] sd_lba,
    output logic        sd_rd,
    output logic        sd_wr,
    input  logic        sd_ack,
    input  logic        sd_buff_wr,
    output logic [7:0]  sd_buff_din,
    output logic [1:0]  owner,
    output logic        busy,
    output logic        timeout_err
);

    typedef enum logic [1:0] {S_IDLE, S_GRANT, S_XFER, S_RELEASE} state_t;

    state_t      state_q, state_d;
    logic [1:0]  ptr_q;
    logic [1:0]  owner_q;
    logic [31:0] sd_lba_q;
    logic        sd_rd_q, sd_wr_q;
    logic [3:0]  pending;
    logic        any_pending;
    logic [1:0]  pick;
    logic [1:0]  cand;
    logic        found;
    logic        owner_rd, owner_wr;
    logic        in_grant;
    logic        keep_req;
    logic        xfer_phase;
    logic [3:0]  owner_mask;
    logic        abort;

    assign pending     = drv_rd | drv_wr;
    assign any_pending = |pending;
    assign owner_rd    = drv_rd[owner_q];
    assign owner_wr    = drv_wr[owner_q];
    assign in_grant    = (state_q == S_GRANT) || (state_q == S_XFER);
    assign owner_mask  = 4'b0001 << owner_q;

    // First pending drive at or after ptr, wrapping modulo 4.
    always_comb begin
        pick  = ptr_q;
        cand  = ptr_q;
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cand = ptr_q + 2'(i);
            if (!found && pending[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
    end

`ifdef SD_ARB_TIMEOUT_EN
    logic [23:0] tmo_cnt_q;
    logic        tmo_err_q;

    assign abort       = in_grant && (tmo_cnt_q == TIMEOUT_CYCLES - 24'd1);
    assign timeout_err = tmo_err_q;

    // Counter is held at zero outside a grant, so it restarts on every GRANT entry.
    always_ff @(negedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            tmo_cnt_q <= 24'd0;
            tmo_err_q <= 1'b0;
        end else begin
            if (in_grant && !abort) begin
                tmo_cnt_q <= tmo_cnt_q + 24'd1;
            end else begin
                tmo_cnt_q <= 24'd0;
            end
            if (abort) begin
                tmo_err_q <= 1'b1;
            end
        end
    end
`else
    assign abort       = 1'b0;
    // Tied low; the parameter only has an effect when the watchdog is built in.
    assign timeout_err = 1'b0 & (TIMEOUT_CYCLES == 24'd0);
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (any_pending && !sd_ack) begin
                    state_d = S_GRANT;
                end
            end
            S_GRANT: begin
                if (abort) begin
                    state_d = S_RELEASE;
                end else if (sd_ack) begin
                    state_d = S_XFER;
                end else if (!owner_rd && !owner_wr) begin
                    state_d = S_IDLE;
                end
            end
            S_XFER: begin
                if (abort || !sd_ack) begin
                    state_d = S_RELEASE;
                end
            end
            S_RELEASE: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Host requests stay asserted only while the grant continues into the next cycle.
    assign keep_req = in_grant && ((state_d == S_GRANT) || (state_d == S_XFER));

    always_ff @(negedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q  <= S_IDLE;
            ptr_q    <= 2'd0;
            owner_q  <= 2'd0;
            sd_lba_q <= 32'd0;
            sd_rd_q  <= 1'b0;
            sd_wr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if ((state_q == S_IDLE) && (state_d == S_GRANT)) begin
                owner_q  <= pick;
                sd_lba_q <= drv_lba[pick];
            end
            if (state_q == S_RELEASE) begin
                ptr_q <= owner_q + 2'd1;
            end
            sd_rd_q <= keep_req & owner_rd;
            sd_wr_q <= keep_req & owner_wr & ~owner_rd;
        end
    end

    // The ack can rise mid-cycle while still in GRANT; pass it (and any bytes)
    // through at once so the drive never misses a strobe.
    assign xfer_phase  = (state_q == S_XFER) || ((state_q == S_GRANT) && sd_ack);
    assign drv_ack     = xfer_phase ? (owner_mask & {4{sd_ack}})     : 4'b0000;
    assign drv_buff_wr = xfer_phase ? (owner_mask & {4{sd_buff_wr}}) : 4'b0000;
    assign sd_buff_din = xfer_phase ? drv_buff_din[owner_q] : 8'h00;

    assign sd_lba = sd_lba_q;
    assign sd_rd  = sd_rd_q;
    assign sd_wr  = sd_wr_q;
    assign owner  = owner_q;
    assign busy   = (state_q != S_IDLE);

endmodule
